dbg_loader: RTL and testbench
=============================

# dbg_loader

Hardware program loader on the debug memory port. Accepts a framed byte stream (typically UART RX) while the CPU is held in reset, and assembles little-endian 32-bit words. Drives them onto the SoC debug bus (`dbg_mem_op`/`dbg_wren`/`dbg_adr`/`dbg_do`) at consecutive word addresses, then releases the CPU. It replaces bench-side `force` preloading with a synthesisable, parametrised path usable on silicon.

## Interface
Parameters:
- `ADR_W`, 32: debug address width.
- `WR_CYCLES`, 4: cycles each debug access is held stable (≥1).
- `MAGIC`, 8'hA5: frame start byte.
- `BOOT_WAIT`, 1: 1 = CPU stays in reset after `n_reset` until a frame with run flag; 0 = CPU runs after reset until a frame begins.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `n_reset` in 1: asynchronous active-low reset.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: byte available.
- `rx_ready` out 1: byte consumed when `rx_valid & rx_ready`.
- `dbg_mem_op` out 1: debug bus owns memory.
- `dbg_wren` out 4: byte write enables.
- `dbg_adr` out ADR_W: debug address.
- `dbg_do` out 32: write data.
- `dbg_di` in 32: read data (used only with verify).
- `cpu_n_reset` out 1: CPU reset, active-low.
- `busy` out 1: frame in progress.
- `err` out 1: last frame aborted.

## Operation
- Frame: `MAGIC`, ADR[4] LE, CNT[2] LE (words), FLG[1] (bit0 = run after load, others ignored), CNT×4 data bytes LE.
- States: IDLE → HADR → HCNT → HFLG → DATA ⇄ WRITE (→ VRFY) → DONE; ERR.
- IDLE: non-`MAGIC` bytes consumed and discarded. `MAGIC` → HADR, `busy`=1, `cpu_n_reset`=0, `err`=0.
- HADR: 4 bytes. If ADR[1:0]≠0 at the end → ERR.
- HCNT: 2 bytes. HFLG: 1 byte; CNT=0 → DONE directly.
- DATA: collects 4 bytes, byte 0 → `dbg_do[7:0]`; on the 4th byte → WRITE.
- WRITE: `dbg_mem_op`=1, `dbg_wren`=4'hF, `dbg_adr`/`dbg_do` stable for WR_CYCLES cycles. Then 1 idle cycle with `dbg_wren`=0 and `dbg_mem_op` still 1. ADR += 4 (mod 2^ADR_W), CNT −= 1; CNT=0 → DONE, else DATA.
- DONE: `dbg_mem_op`=0, `busy`=0. FLG bit0=1 → `cpu_n_reset`=1; else CPU stays in reset. → IDLE.
- ERR: `dbg_mem_op`=0, `err`=1, `busy`=0, `cpu_n_reset`=0. → IDLE. `err` holds until the next `MAGIC`.
- `rx_ready`=1 only in IDLE/HADR/HCNT/HFLG/DATA; 0 in WRITE/VRFY/DONE/ERR.
- `dbg_mem_op`=1 from HADR entry to DONE/ERR, so the CPU never sees a bus gap mid-frame.

## Timing
- Reset values: `rx_ready`=0, `dbg_mem_op`=0, `dbg_wren`=0, `dbg_adr`=0, `dbg_do`=0, `busy`=0, `err`=0, `cpu_n_reset`=0.
- First cycle after reset release: `rx_ready`=1. `cpu_n_reset`=1 if BOOT_WAIT=0.
- Header byte accepted in same cycle as handshake; one byte per cycle max.
- Per word: 4 accept cycles + WR_CYCLES + 1 (+ WR_CYCLES with verify).
- Last write completes → DONE next cycle → `cpu_n_reset` rises the cycle after.
- `n_reset` asserted mid-frame: all state cleared immediately. A partial word is never written.
- `rx_valid` held low mid-frame: FSM waits indefinitely (no timeout).

## Configuration
- `DBG_LOADER_VERIFY_EN` defined:
  - After each WRITE, the VRFY state drives `dbg_wren`=0 and `dbg_mem_op`=1 at the same address for WR_CYCLES cycles.
  - `dbg_di` is sampled on the last cycle. Mismatch → ERR, and no further writes are issued.
- Undefined: VRFY absent, `dbg_di` unused, WRITE → DATA/DONE directly.

## Test plan
- BOOT_WAIT=1, frame A5 00 00 02 00 | 02 00 | 01 | 37 05 02 00 | 6F 00 00 00 → writes 0x00020537 @0x20000, 0x0000006F @0x20004, `dbg_wren`=F each for WR_CYCLES; `cpu_n_reset` rises after the last write; `busy` falls.
- Same frame with FLG=00 → memory written, `cpu_n_reset` stays 0; bytes 11 22 afterwards are discarded in IDLE.
- ADR=0x00020002 → `err`=1 after the 4th address byte, zero writes, `cpu_n_reset`=0; a following valid frame clears `err`.
- CNT=0, FLG=01 → no debug write, `cpu_n_reset`=1 two cycles after the FLG byte.
- `n_reset` pulsed after 2 of 4 data bytes of word 1 → all outputs at reset values, no write of word 1; a fresh frame loads correctly.
- VERIFY_EN, `dbg_di` forced to 0xDEADBEEF while 0x00020537 is expected → `err`=1, only one write issued, CPU held.

Source files
------------

// File: rtl/dbg_loader_if.sv
// rtl/dbg_loader_if.sv - byte stream in and debug memory bus out of the program loader
interface dbg_loader_if #(
  parameter int ADR_W = 32
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             dbg_mem_op;
  logic [3:0]       dbg_wren;
  logic [ADR_W-1:0] dbg_adr;
  logic [31:0]      dbg_do;
  logic [31:0]      dbg_di;

  modport master (
    input  rx_data, rx_valid, dbg_di,
    output rx_ready, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );

  modport slave (
    output rx_data, rx_valid, dbg_di,
    input  rx_ready, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );
endinterface

// File: rtl/dbg_loader.sv
// rtl/dbg_loader.sv - framed byte stream to debug-bus word writes, holds the CPU in reset meanwhile
// Optional read-back check of every written word: DBG_LOADER_VERIFY_EN
module dbg_loader #(
  parameter int         ADR_W     = 32,
  parameter int         WR_CYCLES = 4,
  parameter logic [7:0] MAGIC     = 8'hA5,
  parameter bit         BOOT_WAIT = 1'b1
) (
  input  logic          clk,
  input  logic          n_reset,
  dbg_loader_if.master  bus,
  output logic          cpu_n_reset,
  output logic          busy,
  output logic          err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HADR, S_HCNT, S_HFLG, S_DATA, S_WRITE, S_VRFY, S_DONE, S_ERR
  } state_t;

  localparam int CW = $clog2(WR_CYCLES + 1);

  state_t           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      data_q, data_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             flg_q, flg_d;
  logic [1:0]       idx_q, idx_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             rx_ready_q, rx_ready_d;
  logic             mem_op_q, mem_op_d;
  logic [3:0]       wren_q, wren_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             cpu_q, cpu_d;
  logic             init_q, init_d;
  logic             hs;

  assign hs = bus.rx_valid & rx_ready_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    flg_d   = flg_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    cpu_d   = cpu_q;
    init_d  = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (hs && bus.rx_data == MAGIC) begin
          state_d = S_HADR;
          idx_d   = 2'd0;
          err_d   = 1'b0;
          cpu_d   = 1'b0;
        end
      end
      S_HADR: begin
        if (hs) begin
          data_d = {bus.rx_data, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (data_d[1:0] != 2'b00) begin
              state_d = S_ERR;
            end else begin
              adr_d   = data_d[ADR_W-1:0];
              state_d = S_HCNT;
            end
          end
        end
      end
      S_HCNT: begin
        if (hs) begin
          cnt_d = {bus.rx_data, cnt_q[15:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            idx_d   = 2'd0;
            state_d = S_HFLG;
          end
        end
      end
      S_HFLG: begin
        if (hs) begin
          flg_d   = bus.rx_data[0];
          state_d = (cnt_q == 16'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          data_d = {bus.rx_data, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cyc_d   = '0;
            state_d = S_WRITE;
          end
        end
      end
      // WR_CYCLES strobed cycles, then one idle cycle with the bus still owned
      S_WRITE: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CW'(WR_CYCLES)) begin
          cyc_d = '0;
`ifdef DBG_LOADER_VERIFY_EN
          state_d = S_VRFY;
`else
          adr_d   = adr_q + ADR_W'(4);
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? S_DONE : S_DATA;
`endif
        end
      end
      S_VRFY: begin
`ifdef DBG_LOADER_VERIFY_EN
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CW'(WR_CYCLES - 1)) begin
          cyc_d = '0;
          if (bus.dbg_di != data_q) begin
            state_d = S_ERR;
          end else begin
            adr_d   = adr_q + ADR_W'(4);
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_q == 16'd1) ? S_DONE : S_DATA;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        cpu_d   = flg_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        cpu_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Without boot wait the CPU is let go on the first clock after reset
    if (!init_q && !BOOT_WAIT) cpu_d = 1'b1;
    if (state_d == S_ERR) err_d = 1'b1;

    rx_ready_d = state_d inside {S_IDLE, S_HADR, S_HCNT, S_HFLG, S_DATA};
    mem_op_d   = state_d inside {S_HADR, S_HCNT, S_HFLG, S_DATA, S_WRITE, S_VRFY};
    busy_d     = mem_op_d;
    wren_d     = (state_d == S_WRITE && cyc_d < CW'(WR_CYCLES)) ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      flg_q      <= 1'b0;
      idx_q      <= '0;
      cyc_q      <= '0;
      rx_ready_q <= 1'b0;
      mem_op_q   <= 1'b0;
      wren_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      flg_q      <= flg_d;
      idx_q      <= idx_d;
      cyc_q      <= cyc_d;
      rx_ready_q <= rx_ready_d;
      mem_op_q   <= mem_op_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cpu_q      <= cpu_d;
      init_q     <= init_d;
    end
  end

`ifndef DBG_LOADER_VERIFY_EN
  logic unused_di;
  assign unused_di = ^bus.dbg_di;
`endif

  assign bus.rx_ready   = rx_ready_q;
  assign bus.dbg_mem_op = mem_op_q;
  assign bus.dbg_wren   = wren_q;
  assign bus.dbg_adr    = adr_q;
  assign bus.dbg_do     = data_q;
  assign cpu_n_reset    = cpu_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_dbg_loader.sv
// tb/tb_dbg_loader.sv - directed self-checking bench for dbg_loader
module tb_dbg_loader;

`ifdef DBG_LOADER_VERIFY_EN
  localparam int VC = 4;
`else
  localparam int VC = 0;
`endif

  logic clk = 1'b0;
  logic n_reset;
  logic cpu_n_reset, busy, err;
  logic di_bad = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  dbg_loader_if #(.ADR_W(32)) bus_if ();

  dbg_loader #(.ADR_W(32), .WR_CYCLES(4), .MAGIC(8'hA5), .BOOT_WAIT(1'b1)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus_if),
    .cpu_n_reset(cpu_n_reset), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Memory echo for read-back; di_bad corrupts it
  always_comb bus_if.dbg_di = di_bad ? 32'hDEADBEEF : bus_if.dbg_do;

  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  int          wr_len[$];
  bit          wr_ok[$];
  int          run = 0;
  logic [31:0] run_adr, run_dat;
  bit          run_ok;

  always @(negedge clk) begin
    if (bus_if.dbg_wren === 4'hF) begin
      if (run == 0) begin
        run_adr = bus_if.dbg_adr;
        run_dat = bus_if.dbg_do;
        run_ok  = 1'b1;
        wr_adr.push_back(bus_if.dbg_adr);
        wr_dat.push_back(bus_if.dbg_do);
      end else if (bus_if.dbg_adr !== run_adr || bus_if.dbg_do !== run_dat || bus_if.dbg_mem_op !== 1'b1) begin
        run_ok = 1'b0;
      end
      run++;
    end else if (run != 0) begin
      wr_len.push_back(run);
      wr_ok.push_back(run_ok && bus_if.dbg_mem_op === 1'b1);
      run = 0;
    end
  end

  task automatic clear_log();
    wr_adr.delete(); wr_dat.delete(); wr_len.delete(); wr_ok.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus_if.rx_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte: byte %h not accepted, rx_ready=%b required 1", b, bus_if.rx_ready);
    end
  endtask

  task automatic send_hdr(input logic [31:0] adr, input logic [15:0] cnt, input logic [7:0] flg);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    send_byte(flg);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_if.rx_ready, bus_if.dbg_mem_op, bus_if.dbg_wren, bus_if.dbg_adr, bus_if.dbg_do, busy, err, cpu_n_reset} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b op=%b wren=%h adr=%h do=%h busy=%b err=%b cpu=%b required all 0",
               bus_if.rx_ready, bus_if.dbg_mem_op, bus_if.dbg_wren, bus_if.dbg_adr, bus_if.dbg_do, busy, err, cpu_n_reset);
    end
    n_reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_if.rx_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b required 1", bus_if.rx_ready); end
    n_cmp++;
    if (cpu_n_reset !== 1'b0) begin n_bad++; $display("FAIL post_reset_cpu_held: got %b required 0", cpu_n_reset); end
  endtask

  task automatic test_load_run();
    clear_log();
    send_byte(8'hA5);
    n_cmp++;
    if ({busy, bus_if.dbg_mem_op, cpu_n_reset} !== 3'b110) begin
      n_bad++; $display("FAIL magic_start: busy/op/cpu=%b required 110", {busy, bus_if.dbg_mem_op, cpu_n_reset});
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h00020537);
    send_word(32'h0000006F);
    bus_if.rx_valid = 1'b0;
    n_cmp++;
    if (bus_if.dbg_wren !== 4'hF) begin n_bad++; $display("FAIL last_write_strobe: wren=%h required f", bus_if.dbg_wren); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({bus_if.dbg_wren, bus_if.dbg_mem_op} !== 5'b0000_1) begin
      n_bad++; $display("FAIL idle_cycle: wren=%h op=%b required 0 and 1", bus_if.dbg_wren, bus_if.dbg_mem_op);
    end
    repeat (1 + VC) @(negedge clk);
    n_cmp++;
    if ({busy, bus_if.dbg_mem_op, cpu_n_reset} !== 3'b000) begin
      n_bad++; $display("FAIL done_state: busy/op/cpu=%b required 000", {busy, bus_if.dbg_mem_op, cpu_n_reset});
    end
    @(negedge clk);
    n_cmp++;
    if (cpu_n_reset !== 1'b1) begin n_bad++; $display("FAIL cpu_release: got %b required 1", cpu_n_reset); end
    n_cmp++;
    if (wr_adr.size() != 2) begin
      n_bad++; $display("FAIL run_write_count: got %0d required 2", wr_adr.size());
    end else begin
      n_cmp++;
      if (wr_adr[0] !== 32'h00020000 || wr_dat[0] !== 32'h00020537) begin
        n_bad++; $display("FAIL write0: %h@%h required 00020537@00020000", wr_dat[0], wr_adr[0]);
      end
      n_cmp++;
      if (wr_adr[1] !== 32'h00020004 || wr_dat[1] !== 32'h0000006F) begin
        n_bad++; $display("FAIL write1: %h@%h required 0000006f@00020004", wr_dat[1], wr_adr[1]);
      end
      n_cmp++;
      if (wr_len[0] != 4 || wr_len[1] != 4 || !wr_ok[0] || !wr_ok[1]) begin
        n_bad++; $display("FAIL write_hold: lens %0d,%0d stable %b%b required 4,4 11", wr_len[0], wr_len[1], wr_ok[0], wr_ok[1]);
      end
    end
  endtask

  task automatic test_load_hold();
    clear_log();
    send_hdr(32'h00020000, 16'd2, 8'h00);
    send_word(32'h00020537);
    send_word(32'h0000006F);
    bus_if.rx_valid = 1'b0;
    repeat (10 + VC) @(negedge clk);
    n_cmp++;
    if (cpu_n_reset !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL hold_cpu: cpu=%b busy=%b required 0 0", cpu_n_reset, busy);
    end
    n_cmp++;
    if (wr_dat.size() != 2 || wr_dat[1] !== 32'h0000006F) begin
      n_bad++; $display("FAIL hold_writes: count %0d required 2 ending in 0000006f", wr_dat.size());
    end
    send_byte(8'h11);
    send_byte(8'h22);
    bus_if.rx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, bus_if.dbg_mem_op, cpu_n_reset} !== 3'b000 || wr_dat.size() != 2) begin
      n_bad++; $display("FAIL idle_discard: busy/op/cpu=%b writes=%0d required 000 and 2",
                        {busy, bus_if.dbg_mem_op, cpu_n_reset}, wr_dat.size());
    end
  endtask

  task automatic test_bad_adr();
    clear_log();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    bus_if.rx_valid = 1'b0;
    n_cmp++;
    if ({err, busy, bus_if.dbg_mem_op, cpu_n_reset, bus_if.rx_ready} !== 5'b10000) begin
      n_bad++; $display("FAIL bad_adr_err: err/busy/op/cpu/rdy=%b required 10000",
                        {err, busy, bus_if.dbg_mem_op, cpu_n_reset, bus_if.rx_ready});
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || wr_adr.size() != 0 || bus_if.rx_ready !== 1'b1) begin
      n_bad++; $display("FAIL err_hold: err=%b writes=%0d rdy=%b required 1 0 1", err, wr_adr.size(), bus_if.rx_ready);
    end
  endtask

  task automatic test_cnt_zero();
    clear_log();
    send_byte(8'hA5);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b required 0", err); end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    bus_if.rx_valid = 1'b0;
    n_cmp++;
    if ({cpu_n_reset, busy, bus_if.dbg_mem_op} !== 3'b000) begin
      n_bad++; $display("FAIL cnt0_done: cpu/busy/op=%b required 000", {cpu_n_reset, busy, bus_if.dbg_mem_op});
    end
    @(negedge clk);
    n_cmp++;
    if (cpu_n_reset !== 1'b1 || wr_adr.size() != 0) begin
      n_bad++; $display("FAIL cnt0_release: cpu=%b writes=%0d required 1 0", cpu_n_reset, wr_adr.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    send_hdr(32'h00020000, 16'd2, 8'h01);
    send_byte(8'h37);
    send_byte(8'h05);
    bus_if.rx_valid = 1'b0;
    n_reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.rx_ready, bus_if.dbg_mem_op, bus_if.dbg_wren, bus_if.dbg_adr, bus_if.dbg_do, busy, err, cpu_n_reset} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: op=%b adr=%h do=%h busy=%b cpu=%b required all 0",
                        bus_if.dbg_mem_op, bus_if.dbg_adr, bus_if.dbg_do, busy, cpu_n_reset);
    end
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_adr.size() != 0 || bus_if.rx_ready !== 1'b1) begin
      n_bad++; $display("FAIL partial_word: writes=%0d rdy=%b required 0 1", wr_adr.size(), bus_if.rx_ready);
    end
    send_hdr(32'h00001000, 16'd1, 8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    bus_if.rx_valid = 1'b0;
    repeat (6 + VC) @(negedge clk);
    n_cmp++;
    if (cpu_n_reset !== 1'b1 || wr_adr.size() != 1 || wr_adr[0] !== 32'h00001000 || wr_dat[0] !== 32'hEFBEADDE) begin
      n_bad++; $display("FAIL fresh_frame: cpu=%b writes=%0d required 1 and efbeadde@00001000", cpu_n_reset, wr_adr.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_hdr(32'hFFFFFFFC, 16'd3, 8'h01);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    bus_if.rx_valid = 1'b0;
    repeat (6 + VC) @(negedge clk);
    n_cmp++;
    if (wr_adr.size() != 3) begin
      n_bad++; $display("FAIL wrap_count: got %0d required 3", wr_adr.size());
    end else begin
      n_cmp++;
      if (wr_adr[0] !== 32'hFFFFFFFC || wr_adr[1] !== 32'h00000000 || wr_adr[2] !== 32'h00000004) begin
        n_bad++; $display("FAIL wrap_adr: %h %h %h required fffffffc 00000000 00000004", wr_adr[0], wr_adr[1], wr_adr[2]);
      end
      n_cmp++;
      if (wr_dat[2] !== 32'h33333333 || cpu_n_reset !== 1'b1) begin
        n_bad++; $display("FAIL wrap_data: %h cpu=%b required 33333333 1", wr_dat[2], cpu_n_reset);
      end
    end
  endtask

`ifdef DBG_LOADER_VERIFY_EN
  task automatic test_verify();
    int waited = 0;
    clear_log();
    di_bad = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h00020537);
    bus_if.rx_data  = 8'h6F;
    bus_if.rx_valid = 1'b0;
    while (err !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    bus_if.rx_valid = 1'b0;
    repeat (20) @(negedge clk);
    di_bad = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || wr_adr.size() != 1 || cpu_n_reset !== 1'b0 || bus_if.dbg_mem_op !== 1'b0) begin
      n_bad++; $display("FAIL verify_mismatch: err=%b writes=%0d cpu=%b op=%b required 1 1 0 0",
                        err, wr_adr.size(), cpu_n_reset, bus_if.dbg_mem_op);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_run();
    test_load_hold();
    test_bad_adr();
    test_cnt_zero();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef DBG_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
